// File: rtl/wb_periph_mux.sv
// wb_periph_mux: single-master Wishbone decoder to pinmux (s0) and I2C target (s1); terminates misses/timeouts itself.
// Define WB_MUX_ERR_STATUS_EN to add m_err_o, err_cnt_o and last_err_addr_o.
module wb_periph_mux #(
   parameter int unsigned          ADDR_W      = 32,
   parameter int unsigned          DATA_W      = 32,
   parameter logic [ADDR_W-1:0]    S0_BASE     = 32'h0000_1000,
   parameter logic [ADDR_W-1:0]    S1_BASE     = 32'h0000_2000,
   parameter logic [ADDR_W-1:0]    ADDR_MASK   = 32'h000F_F000,
   parameter int unsigned          TIMEOUT_CYC = 16,
   parameter logic [DATA_W-1:0]    ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [ADDR_W-1:0]     m_addr_i,
   input  logic [DATA_W-1:0]     m_data_i,
   output logic [DATA_W-1:0]     m_data_o,
   input  logic                  m_wr_en_i,
   input  logic [DATA_W/8-1:0]   m_byte_en_i,
   input  logic                  m_stb_i,
   input  logic                  m_cyc_i,
   output logic                  m_ack_o,
`ifdef WB_MUX_ERR_STATUS_EN
   output logic                  m_err_o,
   output logic [7:0]            err_cnt_o,
   output logic [ADDR_W-1:0]     last_err_addr_o,
`endif
   output logic [ADDR_W-1:0]     s_addr_o,
   output logic [DATA_W-1:0]     s_data_o,
   output logic                  s_wr_en_o,
   output logic [DATA_W/8-1:0]   s_byte_en_o,
   output logic                  s0_cyc_o,
   output logic                  s0_stb_o,
   input  logic [DATA_W-1:0]     s0_data_i,
   input  logic                  s0_ack_i,
   output logic                  s1_cyc_o,
   output logic                  s1_stb_o,
   input  logic [DATA_W-1:0]     s1_data_i,
   input  logic                  s1_ack_i
);
   localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_sel;
   logic          w_hit0, w_hit1, w_ack, w_tmo;

   assign w_hit0 = (m_addr_i & ADDR_MASK) == S0_BASE;
   assign w_hit1 = (m_addr_i & ADDR_MASK) == S1_BASE;
   assign w_ack  = r_sel ? s1_ack_i : s0_ack_i;
   assign w_tmo  = m_cyc_i && !w_ack && r_cnt == C_LAST;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_sel <= 1'b0;
         m_data_o <= '0;
         m_ack_o <= 1'b0;
         s_addr_o <= '0;
         s_data_o <= '0;
         s_wr_en_o <= 1'b0;
         s_byte_en_o <= '0;
         {s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o} <= '0;
      end else begin
         case (r_state)
            IDLE: if (m_cyc_i && m_stb_i) begin
               s_addr_o <= m_addr_i;
               s_data_o <= m_data_i;
               s_wr_en_o <= m_wr_en_i;
               s_byte_en_o <= m_byte_en_i;
               r_cnt <= '0;
               if (w_hit0 || w_hit1) begin
                  r_sel <= !w_hit0;
                  {s0_cyc_o, s0_stb_o} <= {2{w_hit0}};
                  {s1_cyc_o, s1_stb_o} <= {2{!w_hit0}};
                  r_state <= ACTIVE;
               end else begin
                  m_data_o <= ERR_DATA;
                  r_state <= RESP;
               end
            end
            ACTIVE: begin
               r_cnt <= r_cnt + 1'b1;
               if (!m_cyc_i || w_ack || w_tmo)
                  {s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o} <= '0;
               if (!m_cyc_i) begin
                  r_state <= IDLE;
               end else if (w_ack || w_tmo) begin
                  m_data_o <= w_ack ? (r_sel ? s1_data_i : s0_data_i) : ERR_DATA;
                  m_ack_o <= 1'b1;
                  r_state <= RESP;
               end
            end
            RESP: begin
               // A miss enters RESP with ack low, so it raises ack one cycle later.
               m_ack_o <= !m_ack_o;
               if (m_ack_o) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef WB_MUX_ERR_STATUS_EN
   logic w_err_evt;

   assign w_err_evt = (r_state == IDLE && m_cyc_i && m_stb_i && !w_hit0 && !w_hit1) ||
                      (r_state == ACTIVE && w_tmo);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_err_o <= 1'b0;
         err_cnt_o <= '0;
         last_err_addr_o <= '0;
      end else begin
         m_err_o <= (r_state == RESP && !m_ack_o) || (r_state == ACTIVE && w_tmo);
         if (w_err_evt) begin
            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 1'b1;
            last_err_addr_o <= (r_state == IDLE) ? m_addr_i : s_addr_o;
         end
      end
   end
`endif
endmodule

// File: tb/tb_wb_periph_mux.sv
// tb_wb_periph_mux: directed plus randomized transfers checked against a transfer-level reference model.
module tb_wb_periph_mux;
   localparam logic [31:0] MASK = 32'h000F_F000;
   localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
   localparam int          TMO  = 16;

   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic [31:0] m_addr_i = '0, m_data_i = '0, m_data_o;
   logic        m_wr_en_i = 1'b0, m_stb_i = 1'b0, m_cyc_i = 1'b0, m_ack_o;
   logic [3:0]  m_byte_en_i = '0, s_byte_en_o;
   logic [31:0] s_addr_o, s_data_o, s0_data_i = '0, s1_data_i = '0;
   logic        s_wr_en_o, s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o;
   logic        s0_ack_i = 1'b0, s1_ack_i = 1'b0;
`ifdef WB_MUX_ERR_STATUS_EN
   logic        m_err_o;
   logic [7:0]  err_cnt_o;
   logic [31:0] last_err_addr_o;
`endif

   int          checks = 0, errors = 0;
   int          m_err_cnt = 0;
   logic [31:0] m_last_err = '0;

   wb_periph_mux dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
      .m_wr_en_i(m_wr_en_i), .m_byte_en_i(m_byte_en_i),
      .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i), .m_ack_o(m_ack_o),
`ifdef WB_MUX_ERR_STATUS_EN
      .m_err_o(m_err_o), .err_cnt_o(err_cnt_o), .last_err_addr_o(last_err_addr_o),
`endif
      .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_wr_en_o(s_wr_en_o), .s_byte_en_o(s_byte_en_o),
      .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s0_data_i(s0_data_i), .s0_ack_i(s0_ack_i),
      .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o), .s1_data_i(s1_data_i), .s1_ack_i(s1_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_strobes"}, {s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o}, 4'b0);
      chk({tag, "_ack"}, m_ack_o, 1'b0);
   endtask

   // dly: stb cycle in which the selected slave acks (0 = never).
   // abort_at: stb cycle at whose middle m_cyc_i drops (or rst_ni pulses when rst_abort).
   task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [3:0] be, input int dly, input logic [31:0] sdata,
                       input int abort_at, input bit rst_abort);
      int tgt, exp_ack, exp_stb, n0, n1, ack_n;
      logic [31:0] exp_data, got_data;
      bit is_err, s_ok, got_err;
      tgt = ((addr & MASK) == 32'h1000) ? 0 : ((addr & MASK) == 32'h2000) ? 1 : -1;
      is_err = (tgt < 0) || dly < 1 || dly > TMO;
      exp_ack = (tgt < 0) ? 2 : is_err ? TMO + 1 : dly + 1;
      exp_data = is_err ? ERR : sdata;
      if (abort_at > 0) exp_ack = 0;
      exp_stb = (tgt < 0) ? 0 : (abort_at > 0) ? abort_at : exp_ack - 1;
      n0 = 0; n1 = 0; ack_n = 0; got_data = '0; s_ok = 1; got_err = 0;
      @(negedge clk_i);
      m_addr_i = addr; m_data_i = wdata; m_wr_en_i = we; m_byte_en_i = be;
      m_cyc_i = 1'b1; m_stb_i = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk_i);
         if (rst_abort && n == abort_at + 1) rst_ni = 1'b1;
         if (s0_stb_o) n0++;
         if (s1_stb_o) n1++;
         if (s0_stb_o || s1_stb_o)
            s_ok &= s_addr_o === addr && s_data_o === wdata && s_wr_en_o === we &&
                    s_byte_en_o === be && s0_cyc_o === s0_stb_o && s1_cyc_o === s1_stb_o;
         if (m_ack_o) begin
            ack_n = n;
            got_data = m_data_o;
`ifdef WB_MUX_ERR_STATUS_EN
            got_err = m_err_o;
`endif
            m_cyc_i = 1'b0; m_stb_i = 1'b0;
            s0_ack_i = 1'b0; s1_ack_i = 1'b0;
            break;
         end
         // Selected slave answers on cue; the other slave babbles and must be ignored.
         s0_ack_i = (tgt == 0) ? (s0_stb_o && n0 == dly) : 1'($urandom_range(0, 1));
         s1_ack_i = (tgt == 1) ? (s1_stb_o && n1 == dly) : 1'($urandom_range(0, 1));
         s0_data_i = (tgt == 0 && s0_ack_i) ? sdata : $urandom;
         s1_data_i = (tgt == 1 && s1_ack_i) ? sdata : $urandom;
         if (abort_at > 0 && n == abort_at) begin
            m_cyc_i = 1'b0; m_stb_i = 1'b0;
            if (rst_abort) begin
               rst_ni = 1'b0;
               m_err_cnt = 0; m_last_err = '0;
               #1 chk_idle_outputs("rst_async");
            end
         end
      end
      s0_ack_i = 1'b0; s1_ack_i = 1'b0;
      chk("ack_cycle", ack_n, exp_ack);
      chk("s0_stb_cycles", n0, (tgt == 0) ? exp_stb : 0);
      chk("s1_stb_cycles", n1, (tgt == 1) ? exp_stb : 0);
      chk("s_fields_stable", s_ok, 1'b1);
      if (abort_at == 0) begin
         chk("read_data", got_data, exp_data);
         if (is_err) begin
            m_err_cnt = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
            m_last_err = addr;
         end
`ifdef WB_MUX_ERR_STATUS_EN
         chk("err_flag", got_err, is_err);
         chk("err_cnt", err_cnt_o, m_err_cnt);
         chk("last_err_addr", last_err_addr_o, m_last_err);
`endif
         @(negedge clk_i);
         chk("ack_pulse_width", m_ack_o, 1'b0);
         chk("data_hold", m_data_o, exp_data);
      end else begin
         chk_idle_outputs("after_abort");
      end
   endtask

   initial begin
      logic [31:0] a;
      int r;
      repeat (2) @(negedge clk_i);
      chk_idle_outputs("reset");
      chk("reset_data", m_data_o, 32'h0);
      chk("reset_s_addr", s_addr_o, 32'h0);
      chk("reset_s_misc", {s_data_o, s_wr_en_o, s_byte_en_o}, 37'h0);
`ifdef WB_MUX_ERR_STATUS_EN
      chk("reset_err", {m_err_o, err_cnt_o, last_err_addr_o}, 41'h0);
`endif
      rst_ni = 1'b1;
      xfer(32'h0000_1000, 32'h0, 1'b0, 4'hF, 3, 32'h1234_5678, 0, 0);
      xfer(32'h0000_2004, 32'hA5A5_0000, 1'b1, 4'b1100, 1, 32'h0BAD_F00D, 0, 0);
      xfer(32'h0000_5000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 0, 0);
      xfer(32'h0000_1000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 0, 0);
      xfer(32'h0000_1008, 32'h0, 1'b0, 4'hF, TMO, 32'hCAFE_0016, 0, 0);
      xfer(32'h0000_1010, 32'h0, 1'b0, 4'hF, 1, 32'h0000_0001, 0, 0);
      xfer(32'h0000_1000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 2, 0);
      xfer(32'h0000_2000, 32'h0, 1'b0, 4'hF, 2, 32'h7777_2000, 0, 0);
      xfer(32'h0000_2000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 3, 1);
      xfer(32'h0000_2000, 32'h0, 1'b0, 4'hF, 4, 32'h5555_AAAA, 0, 0);
      xfer(32'hFFF0_1FFC, 32'h1, 1'b1, 4'b0001, 5, 32'h0F0F_0F0F, 0, 0);
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 2);
         a = $urandom;
         a[19:12] = (r == 0) ? 8'h01 : (r == 1) ? 8'h02 : 8'($urandom_range(3, 255));
         xfer(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom),
              $urandom_range(0, TMO + 2), $urandom, 0, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wb_periph_mux.md
Name: wb_periph_mux

Overview:
- Single-master, two-slave Wishbone interconnect stage downstream of the OBI-to-Wishbone bridge.
- Decodes the translated peripheral address and forwards the transfer to slave 0 (pinmux matrix) or slave 1 (I2C target).
- Returns read data and a one-cycle ack to the bridge.
- Terminates transfers itself on a decode miss or a slave timeout, so the bridge can never hang.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- S0_BASE, 32'h0000_1000, slave 0 (pinmux) base after masking
- S1_BASE, 32'h0000_2000, slave 1 (I2C target) base after masking
- ADDR_MASK, 32'h000F_F000, bits compared for slave select
- TIMEOUT_CYC, 16, max cycles to wait for a slave ack (>=2)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on miss/timeout

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- m_addr_i  in  ADDR_W  master address
- m_data_i  in  DATA_W  master write data
- m_data_o  out  DATA_W  read data to master
- m_wr_en_i  in  1  1=write
- m_byte_en_i  in  DATA_W/8  byte enables
- m_stb_i  in  1  strobe
- m_cyc_i  in  1  cycle
- m_ack_o  out  1  transfer complete, one-cycle pulse
- s_addr_o  out  ADDR_W  shared slave address
- s_data_o  out  DATA_W  shared slave write data
- s_wr_en_o  out  1  shared write enable
- s_byte_en_o  out  DATA_W/8  shared byte enables
- s0_cyc_o, s0_stb_o  out  1 each  slave 0 cycle/strobe
- s0_data_i  in  DATA_W  slave 0 read data
- s0_ack_i  in  1  slave 0 ack
- s1_cyc_o, s1_stb_o  out  1 each  slave 1 cycle/strobe
- s1_data_i  in  DATA_W  slave 1 read data
- s1_ack_i  in  1  slave 1 ack

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0. Reset mid-transfer drops all cyc/stb immediately. No ack is issued for the aborted transfer.
- States: IDLE, ACTIVE, RESP.
- IDLE:
  - Accept condition: m_cyc_i & m_stb_i.
  - On accept, register m_addr_i, m_data_i, m_wr_en_i and m_byte_en_i into the s_* outputs.
  - Compute hit0 = (m_addr_i & ADDR_MASK) == S0_BASE and hit1 likewise for S1_BASE. hit0 has priority if both match.
  - On a hit, register the target select and go to ACTIVE. Clear the counter.
  - On a miss, load m_data_o = ERR_DATA and go to RESP.
- ACTIVE:
  - The selected sN_cyc_o/sN_stb_o are high; the other slave's are low. The counter increments each cycle.
  - On ack from the selected slave, capture its data into m_data_o (also for writes; master ignores it), drop cyc/stb next cycle, and go to RESP.
  - The unselected slave's ack is ignored.
  - If the counter reaches TIMEOUT_CYC-1 with no ack, drop cyc/stb, load ERR_DATA, and go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
  - If m_cyc_i falls during ACTIVE, drop cyc/stb and return to IDLE with no ack (abort).
- RESP: m_ack_o = 1 for exactly one cycle with m_data_o valid, then IDLE. m_data_o holds its value until the next capture.
- Latency: slave ack sampled in cycle k gives m_ack_o in cycle k+1. Decode miss gives m_ack_o two cycles after the accept edge.
- s_* outputs are stable from the first strobe cycle until ack/timeout.
- No pipelining: one outstanding transfer. A new request is accepted only in IDLE, so back-to-back transfers have a 1-cycle IDLE gap.

Optional Feature:
- Macro WB_MUX_ERR_STATUS_EN.
- When defined, adds three outputs:
  - m_err_o (1): high coincident with m_ack_o for miss/timeout only.
  - err_cnt_o (8): saturating count of errors, reset 0.
  - last_err_addr_o (ADDR_W): address of the most recent errored transfer, reset 0.
- When undefined, these ports do not exist and errors are signalled only by ERR_DATA.

Test Plan:
- Read, addr 0x0000_1000, slave 0 acks 3 cycles after stb with 0x1234_5678 -> s0_stb 3 cycles, s1_stb never, m_ack_o one cycle later with m_data_o=0x1234_5678.
- Write, addr 0x0000_2004, data 0xA5A5_0000, byte_en 4'b1100, slave 1 acks in its first stb cycle -> s_data_o/s_byte_en_o match, s_wr_en_o=1, m_ack_o next cycle.
- Read, addr 0x0000_5000 -> no slave strobed, m_ack_o 2 cycles after accept, m_data_o=0xDEAD_BEEF, m_err_o=1 (macro on), err_cnt_o=1, last_err_addr_o=0x0000_5000.
- Slave 0 never acks -> stb held exactly 16 cycles, then m_ack_o with 0xDEAD_BEEF. Repeat with ack in cycle 16 -> slave data returned, no error.
- m_cyc_i dropped on the 2nd ACTIVE cycle, or rst_ni pulsed mid-ACTIVE -> slave cyc/stb low next cycle, no m_ack_o. A following read to 0x0000_2000 completes normally.
